// File: rtl/esc_pwm_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : esc_pwm_generator_pkg
// Brief   : Shared state encoding and width constants for the ESC PWM block
// Revision: 1.0
// ============================================================================
package esc_pwm_generator_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } esc_state_e;

  localparam int CMD_W    = 10;
  localparam int WIDTH_W  = 11;
  localparam int N_MOTORS = 4;

endpackage
`default_nettype wire

// File: rtl/esc_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module  : esc_pwm_channel
// Brief   : One ESC output: rate saturation, sample/active width, comparator
// Revision: 1.0
// ============================================================================
module esc_pwm_channel
  import esc_pwm_generator_pkg::*;
#(
  parameter int N_MOTOR_RATE = 36,
  parameter int MIN_PULSE_US = 1000,
  parameter int MAX_CMD_US   = 1000,
  parameter int US_W         = 12
) (
  input  logic                    sys_clk,
  input  logic                    resetn,
  input  logic [N_MOTOR_RATE-1:0] rate,
  input  logic                    load,
  input  logic                    latch,
  input  logic                    use_sample,
  input  logic [US_W-1:0]         us_cnt,
  output logic                    pwm
);

  localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_PULSE_US);

  logic [CMD_W-1:0]   cmd;
  logic [WIDTH_W-1:0] sample_d, sample_q;
  logic [WIDTH_W-1:0] active_d, active_q;
  logic               pwm_d, pwm_q;

  always_comb begin
    cmd = rate[CMD_W-1:0];
    if (rate[N_MOTOR_RATE-1]) begin
      cmd = '0;
    end else if (rate > N_MOTOR_RATE'(MAX_CMD_US)) begin
      cmd = CMD_W'(MAX_CMD_US);
    end
  end

  // The comparison uses the width being latched this cycle so the first
  // cycle of a frame already reflects the new frame's width.
  always_comb begin
    sample_d = sample_q;
    active_d = active_q;
    if (load) begin
      sample_d = MIN_W + WIDTH_W'(cmd);
    end
    if (latch) begin
      active_d = use_sample ? sample_q : MIN_W;
    end
    pwm_d = (32'(us_cnt) < 32'(active_d));
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      sample_q <= MIN_W;
      active_q <= MIN_W;
      pwm_q    <= 1'b0;
    end else begin
      sample_q <= sample_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule
`default_nettype wire

// File: rtl/esc_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module  : esc_pwm_generator
// Brief   : Four-channel ESC PWM with shared frame timer and arming/failsafe FSM
// Revision: 1.0
// ============================================================================
module esc_pwm_generator
  import esc_pwm_generator_pkg::*;
#(
  parameter int N_MOTOR_RATE = 36,
  parameter int CLKS_PER_US  = 38,
  parameter int FRAME_US     = 2500,
  parameter int MIN_PULSE_US = 1000,
  parameter int MAX_CMD_US   = 1000,
  parameter int ARM_FRAMES   = 200,
  parameter int WDOG_FRAMES  = 20
) (
  input  logic                    sys_clk,
  input  logic                    resetn,
  input  logic [N_MOTOR_RATE-1:0] motor_1_rate,
  input  logic [N_MOTOR_RATE-1:0] motor_2_rate,
  input  logic [N_MOTOR_RATE-1:0] motor_3_rate,
  input  logic [N_MOTOR_RATE-1:0] motor_4_rate,
  input  logic                    rate_update,
  input  logic                    arm_req,
  output logic [N_MOTORS-1:0]     pwm_out,
  output logic                    armed,
  output logic                    failsafe,
  output logic                    frame_start
);

  localparam int PRESC_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int US_W    = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int ARM_W   = $clog2(ARM_FRAMES + 1);
  localparam int WDOG_W  = $clog2(WDOG_FRAMES + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_US - 1);
  localparam logic [US_W-1:0]    US_LAST    = US_W'(FRAME_US - 1);
  localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(ARM_FRAMES - 1);
  localparam logic [WDOG_W-1:0]  WDOG_LIMIT = WDOG_W'(WDOG_FRAMES);

  esc_state_e          state_d, state_q;
  logic [PRESC_W-1:0]  presc_d, presc_q;
  logic [US_W-1:0]     us_cnt_d, us_cnt_q;
  logic [ARM_W-1:0]    arm_cnt_d, arm_cnt_q;
  logic [WDOG_W-1:0]   wdog_cnt_d, wdog_cnt_q;
  logic                frame_start_q;
  logic                us_tick;
  logic                frame_first;

  always_comb begin
    us_tick  = (presc_q == PRESC_LAST);
    presc_d  = us_tick ? '0 : presc_q + 1'b1;
    us_cnt_d = us_cnt_q;
    if (us_tick) begin
      us_cnt_d = (us_cnt_q == US_LAST) ? '0 : us_cnt_q + 1'b1;
    end
  end

  // us_cnt reaches 0 together with the prescaler, so this is its first cycle.
  assign frame_first = (us_cnt_q == '0) && (presc_q == '0);

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    wdog_cnt_d = wdog_cnt_q;
    case (state_q)
      ST_DISARMED: begin
        if (arm_req) begin
          state_d   = ST_ARMING;
          arm_cnt_d = '0;
        end
      end
      ST_ARMING: begin
        if (!arm_req) begin
          state_d = ST_DISARMED;
        end else if (frame_first) begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d    = ST_ARMED;
            wdog_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (!arm_req) begin
          state_d = ST_DISARMED;
        end else if (rate_update) begin
          wdog_cnt_d = '0;
        end else if (frame_first) begin
          if (wdog_cnt_q == WDOG_LIMIT) begin
            state_d = ST_FAILSAFE;
          end else begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
          end
        end
      end
      ST_FAILSAFE: begin
        if (!arm_req) begin
          state_d = ST_DISARMED;
        end
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_DISARMED;
      presc_q       <= '0;
      us_cnt_q      <= '0;
      arm_cnt_q     <= '0;
      wdog_cnt_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      us_cnt_q      <= us_cnt_d;
      arm_cnt_q     <= arm_cnt_d;
      wdog_cnt_q    <= wdog_cnt_d;
      frame_start_q <= frame_first;
    end
  end

  logic [N_MOTOR_RATE-1:0] rate_w [N_MOTORS];
  logic                    load_w;
  logic                    use_sample_w;

  assign rate_w[0]    = motor_1_rate;
  assign rate_w[1]    = motor_2_rate;
  assign rate_w[2]    = motor_3_rate;
  assign rate_w[3]    = motor_4_rate;
  assign load_w       = rate_update && (state_q != ST_FAILSAFE);
  assign use_sample_w = (state_q == ST_ARMED);

  generate
    for (genvar g = 0; g < N_MOTORS; g++) begin : g_chan
      esc_pwm_channel #(
        .N_MOTOR_RATE (N_MOTOR_RATE),
        .MIN_PULSE_US (MIN_PULSE_US),
        .MAX_CMD_US   (MAX_CMD_US),
        .US_W         (US_W)
      ) u_chan (
        .sys_clk    (sys_clk),
        .resetn     (resetn),
        .rate       (rate_w[g]),
        .load       (load_w),
        .latch      (frame_first),
        .use_sample (use_sample_w),
        .us_cnt     (us_cnt_q),
        .pwm        (pwm_out[g])
      );
    end
  endgenerate

  assign armed       = (state_q == ST_ARMED);
  assign failsafe    = (state_q == ST_FAILSAFE);
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_esc_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module  : tb_esc_pwm_generator
// Brief   : Directed vector bench for esc_pwm_generator (small timing params)
// Revision: 1.0
// ============================================================================
module tb_esc_pwm_generator;

  localparam int CLKS       = 2;
  localparam int FRAME      = 50;
  localparam int MINP       = 10;
  localparam int MAXC       = 20;
  localparam int ARMF       = 3;
  localparam int WDOGF      = 2;
  localparam int NR         = 36;
  localparam int FRAME_CLKS = CLKS * FRAME;

  localparam logic [3:0][7:0] MIN4 = {4{8'(MINP)}};

  logic          sys_clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rate_update = 1'b0;
  logic          arm_req = 1'b0;
  logic [NR-1:0] m1 = '0, m2 = '0, m3 = '0, m4 = '0;
  logic [3:0]    pwm_out;
  logic          armed, failsafe, frame_start;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0][NR-1:0] rate;
    logic [3:0][7:0]    exp_us;
  } vec_t;

  vec_t vecs [4];

  always #5 sys_clk = ~sys_clk;

  esc_pwm_generator #(
    .N_MOTOR_RATE (NR),
    .CLKS_PER_US  (CLKS),
    .FRAME_US     (FRAME),
    .MIN_PULSE_US (MINP),
    .MAX_CMD_US   (MAXC),
    .ARM_FRAMES   (ARMF),
    .WDOG_FRAMES  (WDOGF)
  ) dut (
    .sys_clk      (sys_clk),
    .resetn       (resetn),
    .motor_1_rate (m1),
    .motor_2_rate (m2),
    .motor_3_rate (m3),
    .motor_4_rate (m4),
    .rate_update  (rate_update),
    .arm_req      (arm_req),
    .pwm_out      (pwm_out),
    .armed        (armed),
    .failsafe     (failsafe),
    .frame_start  (frame_start)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_fs(input string name);
    int k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (!frame_start && k < 3 * FRAME_CLKS);
    check({name, "_fs"}, longint'(frame_start), 1);
  endtask

  task automatic send(input logic [3:0][NR-1:0] r);
    m1 = r[0];
    m2 = r[1];
    m3 = r[2];
    m4 = r[3];
    rate_update = 1'b1;
    @(negedge sys_clk);
    rate_update = 1'b0;
  endtask

  // Starts on a frame_start cycle, ends on the last cycle of that frame.
  task automatic measure(input string name, input logic [3:0][7:0] exp_us);
    int hi [4];
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      for (int c = 0; c < 4; c++) if (pwm_out[c]) hi[c]++;
      if (i < FRAME_CLKS - 1) @(negedge sys_clk);
    end
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_m%0d_clks", name, c + 1), hi[c], int'(exp_us[c]) * CLKS);
  endtask

  initial begin
    vecs[0].rate   = {36'd0, 36'd0, 36'd0, 36'd5};
    vecs[0].exp_us = {8'd10, 8'd10, 8'd10, 8'd15};
    vecs[1].rate   = {36'd20, 36'd500, 36'hF_FFFF_FFFD, 36'd0};
    vecs[1].exp_us = {8'd30, 8'd30, 8'd10, 8'd10};
    vecs[2].rate   = {36'd1, 36'd19, 36'd21, 36'h8_0000_0000};
    vecs[2].exp_us = {8'd11, 8'd29, 8'd30, 8'd10};
    vecs[3].rate   = {36'd20, 36'd0, 36'h8_0000_0005, 36'h0_0000_0400};
    vecs[3].exp_us = {8'd30, 8'd10, 8'd10, 8'd30};

    step(3);
    check("rst_pwm", pwm_out, 0);
    check("rst_armed", armed, 0);
    check("rst_failsafe", failsafe, 0);
    check("rst_frame_start", frame_start, 0);

    resetn = 1'b1;
    step(1);
    check("first_frame_start", frame_start, 1);
    measure("disarmed", MIN4);
    check("disarmed_armed", armed, 0);

    wait_fs("pre_arm");
    step(10);
    arm_req = 1'b1;
    wait_fs("arm1");
    check("arm1_armed", armed, 0);
    wait_fs("arm2");
    check("arm2_armed", armed, 0);
    wait_fs("arm3");
    check("arm3_armed", armed, 1);
    measure("first_armed_frame", MIN4);

    for (int v = 0; v < 4; v++) begin
      step(5);
      send(vecs[v].rate);
      wait_fs($sformatf("vec%0d", v));
      measure($sformatf("vec%0d", v), vecs[v].exp_us);
    end
    check("vec_failsafe", failsafe, 0);

    wait_fs("wd1");
    check("wd1_failsafe", failsafe, 0);
    check("wd1_armed", armed, 1);
    wait_fs("wd2");
    check("wd2_failsafe", failsafe, 1);
    check("wd2_armed", armed, 0);
    step(5);
    send({4{36'd3}});
    wait_fs("fsafe");
    measure("failsafe", MIN4);

    step(10);
    arm_req = 1'b0;
    step(1);
    check("drop_failsafe", failsafe, 0);
    check("drop_armed", armed, 0);
    arm_req = 1'b1;
    step(1);
    wait_fs("rearm1");
    check("rearm1_armed", armed, 0);
    wait_fs("rearm2");
    check("rearm2_armed", armed, 0);
    wait_fs("rearm3");
    check("rearm3_armed", armed, 1);

    step(FRAME_CLKS - 1);
    check("pre_fs_cycle", frame_start, 0);
    send({4{36'd7}});
    check("fs_update_cycle", frame_start, 1);
    measure("same_frame", vecs[3].exp_us);
    wait_fs("next_frame");
    measure("next_frame", {4{8'd17}});

    wait_fs("mid_rst");
    step(10);
    check("pre_rst_pwm", pwm_out, 4'hf);
    resetn  = 1'b0;
    arm_req = 1'b0;
    #1;
    check("mid_rst_pwm", pwm_out, 0);
    check("mid_rst_armed", armed, 0);
    step(3);
    resetn = 1'b1;
    step(1);
    check("post_rst_frame_start", frame_start, 1);
    measure("post_rst", MIN4);
    check("post_rst_armed", armed, 0);
    check("post_rst_failsafe", failsafe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
